updn_counter_ctrl: RTL

Sequencer for the cascaded up/down binary counter. It accepts a target value through a valid/ready command port. It then drives the counter's `eup`/`edn` enables one step per cycle until the counter output equals the target, and pulses `done`. The block sits between a host or control FSM and the counter cascade, so no requester toggles the enables directly.

---
 rtl/updn_counter_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/updn_counter_ctrl.sv
// Command sequencer for the cascaded up/down counter: accepts a target value and
// steps the counter one count per cycle until it reaches it, then pulses done.
module updn_counter_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_target,
    input  logic         cmd_mode,
    input  logic         cmd_abort,
    input  logic [W-1:0] q_in,
    output logic         eup,
    output logic         edn,
    output logic         busy,
    output logic         done,
    output logic         aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_target;
    logic           r_mode;
    logic           r_aborted;

    logic           w_atTarget;
    logic [W-1:0]   w_distUp;
    logic [W-1:0]   w_distDown;
    logic           w_goUp;

    // Modular distances; a tie between them resolves toward counting up.
    assign w_atTarget = (q_in == r_target);
    assign w_distUp   = r_target - q_in;
    assign w_distDown = q_in - r_target;
    assign w_goUp     = r_mode ? (w_distUp <= w_distDown) : (q_in < r_target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_target  <= '0;
            r_mode    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_target  <= cmd_target;
                        r_mode    <= cmd_mode;
                        r_aborted <= 1'b0;
                        r_state   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_atTarget) begin
                        r_state <= S_DONE;
                    end else if (w_goUp) begin
                        r_state <= S_UP;
                    end else begin
                        r_state <= S_DOWN;
                    end
                end
                S_UP, S_DOWN: begin
                    if (cmd_abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_atTarget) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Enables stay combinational so an abort or an early arrival cuts them in the same cycle.
    assign eup       = (r_state == S_UP)   && !w_atTarget && !cmd_abort;
    assign edn       = (r_state == S_DOWN) && !w_atTarget && !cmd_abort;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign aborted   = r_aborted;

endmodule
